hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Drives the forwarding selects (ForwardA/ForwardB) and bubble enable (MuxControlEn) of the decode stage.
- Drives the PC and IF/ID write enables, and the fetch flush.
- Keeps a shadow scoreboard of the destination registers in EX/MEM/WB, sequences load-use stalls, branch flushes and memory-busy freezes, and counts stall/flush cycles.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush is held after a taken branch (1..3)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
Reg1  in  5  decode rs1 (already 0 when unused)
Reg2  in  5  decode rs2 (already 0 when unused)
WriteRegOut  in  5  decode rd
RegWriteOut  in  1  decode instruction writes rd
MemRead  in  1  decode instruction is a load
IdValid  in  1  IF/ID holds a valid instruction
BranchTaken  in  1  EX resolved a taken branch/jump this cycle
MemBusy  in  1  data memory not ready; freeze the pipeline
ForwardA  out  2  rs1 select: 3=EX ALU, 2=MEM ALU, 1=WB data, 0=regfile
ForwardB  out  2  rs2 select, same encoding
MuxControlEn  out  1  0 zeroes decode control (bubble into ID/EX)
PCWrite  out  1  PC update enable
IfIdWrite  out  1  IF/ID register enable
Flush  out  1  kill the IF/ID contents
StallCount  out  CNT_W  load-use plus MemBusy stall cycles
FlushCount  out  CNT_W  taken-branch events

Behaviour:
- Shadow stages EX, MEM, WB each hold {valid, rd, regwrite, memread}.
- A stage "hits" rsN when: valid & regwrite & rd==rsN & rsN!=0.
- Forwarding (combinational):
  - priority EX hit -> 3, else MEM hit -> 2, else WB hit -> 1, else 0.
  - A hit whose stage has memread=1 in EX or MEM is not forwarded; it raises LoadHaz instead.
  - A load hit in WB forwards 1.
- LoadHaz = IdValid & (load hit on Reg1 or Reg2 in EX or MEM).
- Load-use stall, when LoadHaz and not flushing:
  - PCWrite=0, IfIdWrite=0, MuxControlEn=0.
  - A bubble enters EX. EX/MEM/WB advance.
  - Typically 2 stall cycles for a dependent load in EX, 1 cycle if the load is in MEM.
- State machine:
  - RUN: normal operation.
  - FLUSH: a down-counter loaded with FLUSH_CYCLES-1.
  - RUN -> FLUSH when BranchTaken & !MemBusy; Flush=1 that cycle.
  - In FLUSH: Flush=1, MuxControlEn=0, PCWrite=1, IfIdWrite=1. Return to RUN when the counter reaches 0 (with MemBusy=0).
  - FLUSH_CYCLES=1 -> a one-cycle flush; the FSM stays in RUN.
- Flush dominates a load-use stall: the ID instruction is killed, no stall is counted, and a bubble enters EX.
- Shadow advance, each cycle with MemBusy=0:
  - WB<=MEM, MEM<=EX.
  - EX<= decode fields with valid=IdValid & MuxControlEn.
- MemBusy=1 dominates everything:
  - All shadow stages, the FSM and the flush counter hold.
  - PCWrite=0, IfIdWrite=0, MuxControlEn=1.
  - ForwardA/B are still computed from the held state.
  - BranchTaken is ignored; EX re-presents it once MemBusy drops.
- Counters:
  - StallCount +1 per cycle with MemBusy, or per cycle with LoadHaz & !flush.
  - FlushCount +1 per RUN->FLUSH entry.
  - Both wrap modulo 2^CNT_W.
- Reset (synchronous; takes effect at the clock edge, including mid-stall or mid-flush):
  - all stages invalid, FSM=RUN, counter=0, counts=0.
  - Outputs after reset: ForwardA=ForwardB=0, MuxControlEn=1, PCWrite=1, IfIdWrite=1, Flush=0.
- x0 never forwards and never stalls.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e {FWD_REG=0, FWD_WB=1, FWD_MEM=2, FWD_EXE=3}
  - stage_t struct {valid, rd[4:0], regwrite, memread}
  - fsm_e {RUN, FLUSH}
- One sub-module, hazard_fwd_sel: a combinational per-operand priority select plus LoadHaz term, instantiated twice (rs1, rs2).

Test Plan:
- ALU hit in EX:
  - `add x5` then `sub` with rs1=x5 -> ForwardA=3.
  - one cycle later, MEM hit -> ForwardA=2.
  - next cycle, WB hit -> ForwardA=1, no stall.
- Load-use:
  - `lw x6` then `add` with rs2=x6 -> 2 cycles of PCWrite=IfIdWrite=MuxControlEn=0.
  - then ForwardB=1, StallCount=2.
- Priority: x7 written in EX and MEM simultaneously -> ForwardA=3.
- x0: Reg1=0 with every stage rd=0 -> ForwardA=0, no stall.
- Branch with FLUSH_CYCLES=2:
  - BranchTaken pulse -> Flush=1 for exactly 2 cycles, MuxControlEn=0, FlushCount=1.
  - Coincident LoadHaz -> no stall counted.
- MemBusy for 3 cycles during a load-use stall:
  - PCWrite=0, shadow state and Forward selects frozen, StallCount +3.
  - On release, remaining load-use stall cycles resume.
  - rst asserted mid-FLUSH -> next cycle Flush=0, all counts 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// shadow pipeline stage record and the flush sequencer states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EXE = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } stage_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_e;

  localparam stage_t STAGE_EMPTY = '0;

  // x0 is hard-wired, so a zero source register can never match a producer.
  function automatic logic stage_hit(input stage_t s, input logic [4:0] rs);
    return s.valid && s.regwrite && (s.rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding priority select; flags a load producer still in
// EX or MEM, whose data is not yet available for forwarding.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  stage_t     ex,
  input  stage_t     mem,
  input  stage_t     wb,
  output fwd_sel_e   sel,
  output logic       load_hit
);

  // The youngest matching producer wins; a load there blocks older stages.
  always_comb begin
    sel      = FWD_REG;
    load_hit = 1'b0;
    if (stage_hit(ex, rs)) begin
      if (ex.memread) load_hit = 1'b1;
      else            sel      = FWD_EXE;
    end else if (stage_hit(mem, rs)) begin
      if (mem.memread) load_hit = 1'b1;
      else             sel      = FWD_MEM;
    end else if (stage_hit(wb, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB scoreboard, forwarding,
// load-use stalls, taken-branch flush sequencing and stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Reg1,
  input  logic [4:0]       Reg2,
  input  logic [4:0]       WriteRegOut,
  input  logic             RegWriteOut,
  input  logic             MemRead,
  input  logic             IdValid,
  input  logic             BranchTaken,
  input  logic             MemBusy,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             MuxControlEn,
  output logic             PCWrite,
  output logic             IfIdWrite,
  output logic             Flush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  stage_t     ex_q, mem_q, wb_q;
  fsm_e       state, state_next;
  logic [1:0] flush_cnt, flush_cnt_next;
  fwd_sel_e   sel_a, sel_b;
  logic       hit_a, hit_b;
  logic       load_haz, branch_now, flushing;

  hazard_fwd_sel u_fwd_a (
    .rs       (Reg1),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (sel_a),
    .load_hit (hit_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs       (Reg2),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (sel_b),
    .load_hit (hit_b)
  );

  assign ForwardA   = sel_a;
  assign ForwardB   = sel_b;
  assign load_haz   = IdValid & (hit_a | hit_b);
  assign branch_now = (state == RUN) & BranchTaken & ~MemBusy;
  assign flushing   = (state == FLUSH) | branch_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // A one-cycle flush is covered entirely by the entry cycle in RUN.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    if (!MemBusy) begin
      case (state)
        RUN: begin
          if (BranchTaken && (FLUSH_CYCLES > 1)) begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_LOAD;
          end
        end
        FLUSH: begin
          flush_cnt_next = flush_cnt - 2'd1;
          if (flush_cnt == 2'd1) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    PCWrite      = 1'b1;
    IfIdWrite    = 1'b1;
    MuxControlEn = 1'b1;
    Flush        = flushing;
    if (MemBusy) begin
      PCWrite   = 1'b0;
      IfIdWrite = 1'b0;
    end else if (flushing) begin
      MuxControlEn = 1'b0;
    end else if (load_haz) begin
      PCWrite      = 1'b0;
      IfIdWrite    = 1'b0;
      MuxControlEn = 1'b0;
    end
  end

  // Shadow scoreboard and counters; a busy memory freezes the shadow stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= STAGE_EMPTY;
      mem_q      <= STAGE_EMPTY;
      wb_q       <= STAGE_EMPTY;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!MemBusy) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= {IdValid & MuxControlEn, WriteRegOut, RegWriteOut, MemRead};
      end
      if (MemBusy || (load_haz && !flushing)) StallCount <= StallCount + 1'b1;
      if (branch_now) FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule
